// File: rtl/xg_dmem_mmio.sv
// Data-memory responder for the xgriscv data port: byte-lane word RAM plus an MMIO window
// (LED, cycle counter, compare timer, synchronised switches). Timer built when XG_DMEM_TIMER_EN is defined.
module xg_dmem_mmio #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [3:0]  amp,
    input  logic [31:0] daddr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic [15:0] sw,
    output logic [31:0] leds,
    output logic        timer_irq
);
    localparam int AW = $clog2(DEPTH_WORDS);

    localparam logic [7:0] OFF_LED    = 8'h00;
    localparam logic [7:0] OFF_CYCLE  = 8'h04;
    localparam logic [7:0] OFF_CMP    = 8'h08;
    localparam logic [7:0] OFF_STATUS = 8'h0C;
    localparam logic [7:0] OFF_SW     = 8'h10;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] widx;
    logic          is_mmio;
    logic [7:0]    offset;
    logic          ram_we;
    logic          mmio_we;
    logic [31:0]   cycle_q;
    logic [15:0]   sw_meta;
    logic [15:0]   sw_sync;
    logic          unused_bits;

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  lanes);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i*8 +: 8] = lanes[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
        end
        return r;
    endfunction

    assign is_mmio     = (daddr[31:16] == 16'hFFFF);
    assign offset      = daddr[7:0];
    assign widx        = daddr[AW+1:2];
    // Reset dominates a coincident store, so the RAM write is suppressed too.
    assign ram_we      = memwrite && !is_mmio && !reset;
    assign mmio_we     = memwrite && is_mmio;
    assign unused_bits = ^daddr;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (amp[i]) mem[widx][i*8 +: 8] <= writedata[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            leds    <= '0;
            cycle_q <= '0;
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            sw_meta <= sw;
            sw_sync <= sw_meta;
            if (mmio_we && offset == OFF_LED) leds <= merge_lanes(leds, writedata, amp);
        end
    end

`ifdef XG_DMEM_TIMER_EN
    logic [31:0] cmp_q;
    logic        hit_q;
    logic        match;
    logic        clear;

    // Match is taken from registered values, so a CMP write on the matching edge uses the old CMP.
    assign match = (cycle_q == cmp_q) && (cmp_q != 32'd0);
    assign clear = mmio_we && offset == OFF_STATUS && amp[0] && writedata[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            cmp_q <= '0;
            hit_q <= 1'b0;
        end else begin
            if (mmio_we && offset == OFF_CMP) cmp_q <= merge_lanes(cmp_q, writedata, amp);
            if (match)      hit_q <= 1'b1;
            else if (clear) hit_q <= 1'b0;
        end
    end

    assign timer_irq = hit_q;
`else
    assign timer_irq = 1'b0;
`endif

    always_comb begin
        readdata = '0;
        if (is_mmio) begin
            case (offset)
                OFF_LED:    readdata = leds;
                OFF_CYCLE:  readdata = cycle_q;
`ifdef XG_DMEM_TIMER_EN
                OFF_CMP:    readdata = cmp_q;
                OFF_STATUS: readdata = {31'b0, hit_q};
`endif
                OFF_SW:     readdata = {16'b0, sw_sync};
                default:    readdata = '0;
            endcase
        end else begin
            readdata = mem[widx];
        end
    end
endmodule
